pipeline_ctrl_regs: RTL and testbench

PIPELINE_CTRL_REGS -- requirements
Module: pipeline_ctrl_regs

---
 rtl/pipe_ctrl_pkg.sv | 42 ++++
 rtl/ctrl_stage_reg.sv | 26 ++
 rtl/pipeline_ctrl_regs.sv | 124 ++++++++++++
 tb/tb_pipeline_ctrl_regs.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// pipe_ctrl_pkg: control-field widths, per-stage payload layouts and bubble
// constants shared by the pipeline control register chain.
package pipe_ctrl_pkg;

  localparam int ALU_W = 6;
  localparam int EXC_W = 7;
  localparam int MEM_W = 5;
  localparam int WR_W  = 2;
  localparam int RW_W  = 5;

  typedef struct packed {
    logic             valid;
    logic [ALU_W-1:0] alu_ctrl;
    logic [EXC_W-1:0] ex_ctrl;
    logic [MEM_W-1:0] mem_ctrl;
    logic [WR_W-1:0]  wr_ctrl;
    logic [RW_W-1:0]  rw;
    logic             is_load;
  } ex_stage_t;

  // EX-only fields (alu/ex control) are dropped here.
  typedef struct packed {
    logic             valid;
    logic [MEM_W-1:0] mem_ctrl;
    logic [WR_W-1:0]  wr_ctrl;
    logic [RW_W-1:0]  rw;
    logic             is_load;
  } mem_stage_t;

  typedef struct packed {
    logic            valid;
    logic [WR_W-1:0] wr_ctrl;
    logic [RW_W-1:0] rw;
  } wb_stage_t;

  localparam ex_stage_t  EX_BUBBLE  = '0;
  localparam mem_stage_t MEM_BUBBLE = '0;
  localparam wb_stage_t  WB_BUBBLE  = '0;

endpackage
`default_nettype wire

// File: rtl/ctrl_stage_reg.sv
`default_nettype none
// ctrl_stage_reg: W-bit pipeline register, asynchronously cleared, loading
// the BUBBLE pattern instead of d when bubble is high.
module ctrl_stage_reg #(
  parameter int           W      = 8,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (bubble) begin
      q <= BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl_regs.sv
`default_nettype none
// pipeline_ctrl_regs: ID->EX->MEM->WB control register chain with bubble
// insertion on stall/flush and saturating bubble/flush event counters.
module pipeline_ctrl_regs
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [ALU_W-1:0] aluCtrl_id,
  input  logic [EXC_W-1:0] exCtrl_id,
  input  logic [MEM_W-1:0] memCtrl_id,
  input  logic [WR_W-1:0]  wrCtrl_id,
  input  logic [RW_W-1:0]  rW_id,
  input  logic             isLoad_id,
  output logic [ALU_W-1:0] aluCtrl_ex,
  output logic [EXC_W-1:0] exCtrl_ex,
  output logic             valid_ex,
  output logic [RW_W-1:0]  rW_ex,
  output logic             isLoad_ex,
  output logic [MEM_W-1:0] memCtrl_mem,
  output logic             valid_mem,
  output logic [RW_W-1:0]  rW_mem,
  output logic             isLoad_mem,
  output logic [WR_W-1:0]  wrCtrl_wb,
  output logic             valid_wb,
  output logic [RW_W-1:0]  rW_wb,
  output logic             regWr_wb,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_stage_t  ex_d,  ex_q;
  mem_stage_t mem_d, mem_q;
  wb_stage_t  wb_d,  wb_q;
  logic       ex_bubble;

  // An empty ID slot enters EX as a bubble too, so downstream fields stay 0.
  assign ex_bubble = stall | flush | ~id_valid;

  always_comb begin
    ex_d          = EX_BUBBLE;
    ex_d.valid    = id_valid;
    ex_d.alu_ctrl = aluCtrl_id;
    ex_d.ex_ctrl  = exCtrl_id;
    ex_d.mem_ctrl = memCtrl_id;
    ex_d.wr_ctrl  = wrCtrl_id;
    ex_d.rw       = rW_id;
    ex_d.is_load  = isLoad_id;
  end

  always_comb begin
    mem_d          = MEM_BUBBLE;
    mem_d.valid    = ex_q.valid;
    mem_d.mem_ctrl = ex_q.mem_ctrl;
    mem_d.wr_ctrl  = ex_q.wr_ctrl;
    mem_d.rw       = ex_q.rw;
    mem_d.is_load  = ex_q.is_load;
  end

  always_comb begin
    wb_d         = WB_BUBBLE;
    wb_d.valid   = mem_q.valid;
    wb_d.wr_ctrl = mem_q.wr_ctrl;
    wb_d.rw      = mem_q.rw;
  end

  ctrl_stage_reg #(.W($bits(ex_stage_t)), .BUBBLE(EX_BUBBLE)) u_ex_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (ex_bubble),
    .d      (ex_d),
    .q      (ex_q)
  );

  ctrl_stage_reg #(.W($bits(mem_stage_t)), .BUBBLE(MEM_BUBBLE)) u_mem_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .d      (mem_d),
    .q      (mem_q)
  );

  ctrl_stage_reg #(.W($bits(wb_stage_t)), .BUBBLE(WB_BUBBLE)) u_wb_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .d      (wb_d),
    .q      (wb_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (stall && (bubble_cnt != CNT_MAX)) bubble_cnt <= bubble_cnt + CNT_ONE;
      if (flush && (flush_cnt != CNT_MAX))  flush_cnt  <= flush_cnt + CNT_ONE;
    end
  end

  assign aluCtrl_ex  = ex_q.alu_ctrl;
  assign exCtrl_ex   = ex_q.ex_ctrl;
  assign valid_ex    = ex_q.valid;
  assign rW_ex       = ex_q.rw;
  assign isLoad_ex   = ex_q.is_load;
  assign memCtrl_mem = mem_q.mem_ctrl;
  assign valid_mem   = mem_q.valid;
  assign rW_mem      = mem_q.rw;
  assign isLoad_mem  = mem_q.is_load;
  assign wrCtrl_wb   = wb_q.wr_ctrl;
  assign valid_wb    = wb_q.valid;
  assign rW_wb       = wb_q.rw;
  assign regWr_wb    = wb_q.valid & wb_q.wr_ctrl[1];

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl_regs.sv
`default_nettype none
// tb_pipeline_ctrl_regs: scoreboard bench for the pipeline control chain;
// expected stage records are queued at drive time and retired stage by stage.
module tb_pipeline_ctrl_regs;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall, flush, id_valid;
  logic [5:0]       aluCtrl_id;
  logic [6:0]       exCtrl_id;
  logic [4:0]       memCtrl_id;
  logic [1:0]       wrCtrl_id;
  logic [4:0]       rW_id;
  logic             isLoad_id;
  logic [5:0]       aluCtrl_ex;
  logic [6:0]       exCtrl_ex;
  logic             valid_ex;
  logic [4:0]       rW_ex;
  logic             isLoad_ex;
  logic [4:0]       memCtrl_mem;
  logic             valid_mem;
  logic [4:0]       rW_mem;
  logic             isLoad_mem;
  logic [1:0]       wrCtrl_wb;
  logic             valid_wb;
  logic [4:0]       rW_wb;
  logic             regWr_wb;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  pipeline_ctrl_regs #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .id_valid    (id_valid),
    .aluCtrl_id  (aluCtrl_id),
    .exCtrl_id   (exCtrl_id),
    .memCtrl_id  (memCtrl_id),
    .wrCtrl_id   (wrCtrl_id),
    .rW_id       (rW_id),
    .isLoad_id   (isLoad_id),
    .aluCtrl_ex  (aluCtrl_ex),
    .exCtrl_ex   (exCtrl_ex),
    .valid_ex    (valid_ex),
    .rW_ex       (rW_ex),
    .isLoad_ex   (isLoad_ex),
    .memCtrl_mem (memCtrl_mem),
    .valid_mem   (valid_mem),
    .rW_mem      (rW_mem),
    .isLoad_mem  (isLoad_mem),
    .wrCtrl_wb   (wrCtrl_wb),
    .valid_wb    (valid_wb),
    .rW_wb       (rW_wb),
    .regWr_wb    (regWr_wb),
    .bubble_cnt  (bubble_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [5:0] alu;
    logic [6:0] exc;
    logic [4:0] mem;
    logic [1:0] wr;
    logic [4:0] rw;
    logic       ld;
  } rec_t;

  rec_t q_ex[$];
  rec_t q_mem[$];
  rec_t q_wb[$];

  int n_checks = 0;
  int n_errors = 0;
  logic [CNT_W-1:0] exp_bub = '0;
  logic [CNT_W-1:0] exp_fl  = '0;
  int ex_valid_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] alu, input logic [6:0] exc,
                       input logic [4:0] mem, input logic [1:0] wr, input logic [4:0] rw,
                       input logic ld, input logic st, input logic fl);
    id_valid   = v;
    aluCtrl_id = alu;
    exCtrl_id  = exc;
    memCtrl_id = mem;
    wrCtrl_id  = wr;
    rW_id      = rw;
    isLoad_id  = ld;
    stall      = st;
    flush      = fl;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 7'd0, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: queue expected EX record, then retire WB, MEM, EX in order.
  task automatic step();
    rec_t e, x, m, w;
    e = '0;
    if (!stall && !flush && id_valid) begin
      e.v = 1'b1; e.alu = aluCtrl_id; e.exc = exCtrl_id; e.mem = memCtrl_id;
      e.wr = wrCtrl_id; e.rw = rW_id; e.ld = isLoad_id;
    end
    q_ex.push_back(e);
    if (stall && exp_bub != '1) exp_bub = exp_bub + 1'b1;
    if (flush && exp_fl != '1)  exp_fl  = exp_fl + 1'b1;
    @(posedge clk);
    #1;
    if (q_wb.size() > 0) begin
      w = q_wb.pop_front();
      check("valid_wb", valid_wb, w.v);
      check("wrCtrl_wb", wrCtrl_wb, w.wr);
      check("rW_wb", rW_wb, w.rw);
      check("regWr_wb", regWr_wb, w.v & w.wr[1]);
    end
    if (q_mem.size() > 0) begin
      m = q_mem.pop_front();
      check("valid_mem", valid_mem, m.v);
      check("memCtrl_mem", memCtrl_mem, m.mem);
      check("rW_mem", rW_mem, m.rw);
      check("isLoad_mem", isLoad_mem, m.ld);
      q_wb.push_back(m);
    end
    x = q_ex.pop_front();
    check("valid_ex", valid_ex, x.v);
    check("aluCtrl_ex", aluCtrl_ex, x.alu);
    check("exCtrl_ex", exCtrl_ex, x.exc);
    check("rW_ex", rW_ex, x.rw);
    check("isLoad_ex", isLoad_ex, x.ld);
    q_mem.push_back(x);
    check("bubble_cnt", bubble_cnt, exp_bub);
    check("flush_cnt", flush_cnt, exp_fl);
    if (valid_ex) ex_valid_seen++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid_ex"}, valid_ex, 0);
    check({tag, "_valid_mem"}, valid_mem, 0);
    check({tag, "_valid_wb"}, valid_wb, 0);
    check({tag, "_regWr_wb"}, regWr_wb, 0);
    check({tag, "_ctrl"}, {aluCtrl_ex, exCtrl_ex, memCtrl_mem, wrCtrl_wb}, 0);
    check({tag, "_rw"}, {rW_ex, rW_mem, rW_wb, isLoad_ex, isLoad_mem}, 0);
    check({tag, "_cnt"}, {bubble_cnt, flush_cnt}, 0);
  endtask

  task automatic clear_model();
    q_ex.delete(); q_mem.delete(); q_wb.delete();
    exp_bub = '0;
    exp_fl  = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk); @(posedge clk); #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Straight-line flow
    drive(1'b1, 6'd0, 7'd0, 5'd0, 2'b10, 5'd3, 1'b0, 1'b0, 1'b0); step();
    check("flow_rW_ex", rW_ex, 3);
    idle(); step();
    check("flow_rW_mem", rW_mem, 3);
    step();
    check("flow_regWr_wb", regWr_wb, 1);
    check("flow_rW_wb", rW_wb, 3);
    step();

    // Load-use stall: load enters EX, dependent held in ID one cycle
    drive(1'b1, 6'h01, 7'h02, 5'b00001, 2'b10, 5'd7, 1'b1, 1'b0, 1'b0); step();
    check("lu_isLoad_ex", isLoad_ex, 1);
    check("lu_rW_ex", rW_ex, 7);
    drive(1'b1, 6'h05, 7'h11, 5'd0, 2'b10, 5'd9, 1'b0, 1'b1, 1'b0); step();
    check("lu_bubble_ex", valid_ex, 0);
    drive(1'b1, 6'h05, 7'h11, 5'd0, 2'b10, 5'd9, 1'b0, 1'b0, 1'b0); step();
    check("lu_release_ex", valid_ex, 1);
    check("lu_bubble_cnt", bubble_cnt, 1);
    idle(); step(); step();

    // Flush with a store one cycle ahead of it
    drive(1'b1, 6'h0A, 7'h03, 5'b00100, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0); step();
    ex_valid_seen = 0;
    drive(1'b1, 6'h3F, 7'h7F, 5'b11111, 2'b11, 5'd31, 1'b1, 1'b0, 1'b1); step();
    check("fl_store_mem", memCtrl_mem[2], 1);
    check("fl_killed_ex", valid_ex, 0);
    idle(); step();
    check("fl_store_wb", valid_wb, 1);
    check("fl_no_regwr", regWr_wb, 0);
    check("fl_ex_valid_seen", ex_valid_seen, 0);
    check("fl_flush_cnt", flush_cnt, 1);
    step();

    // Simultaneous stall and flush for three cycles
    ex_valid_seen = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'h15, 7'h2A, 5'b10101, 2'b10, 5'(i + 1), 1'b0, 1'b1, 1'b1); step();
    end
    check("sf_ex_valid_seen", ex_valid_seen, 0);
    check("sf_bubble_cnt", bubble_cnt, 4);
    check("sf_flush_cnt", flush_cnt, 4);
    idle(); step(); step();

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom), 6'($urandom), 7'($urandom), 5'($urandom), 2'($urandom),
            5'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 4) == 0));
      step();
    end

    // Asynchronous reset with three valid stages in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'h01, 7'h01, 5'b00100, 2'b10, 5'(10 + i), 1'b0, 1'b0, 1'b0); step();
    end
    check("ar_pre_valid_wb", valid_wb, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    clear_model();
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 6'h02, 7'h04, 5'd0, 2'b10, 5'd4, 1'b0, 1'b1, 1'b0); step();
    end
    check("sat_bubble_cnt", bubble_cnt, 15);
    check("sat_flush_cnt", flush_cnt, 0);
    idle(); step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
